jam_sched: RTL

- Job-assignment scheduler that sequences the 8-digit permutation engine.
- Per permutation: requests the next candidate, reads 8 worker/job costs from the cost ROM, sums them, and tracks the minimum total and how many assignments reach it.
- Sits between the top-level start/result interface, the permutation engine and the cost ROM.

---
 rtl/jam_pkg.sv | 44 ++++
 rtl/jam_cost_acc.sv | 121 ++++++++++++
 rtl/jam_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/jam_pkg.sv
// ---------------------------------------------------------------------------
// jam_pkg
// Shared definitions for the job-assignment scheduler (jam_sched) and its
// cost accumulator (jam_cost_acc).
//   - default widths N, COST_W, SUM_W, CNT_W and the address width IDX_W
//   - MIN_INIT: all-ones start value of the running minimum
//   - state_t: scheduler state encoding
//   - sat_inc: saturating increment for the match counter
// Optional feature macro used by the including modules: JAM_EARLY_ABORT_EN
// ---------------------------------------------------------------------------
package jam_pkg;

    localparam int N      = 8;
    localparam int COST_W = 7;
    localparam int SUM_W  = 10;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = 3;

    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(N - 1);
    localparam logic [SUM_W-1:0] MIN_INIT = {SUM_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_FETCH = 3'd3,
        S_ACC   = 3'd4,
        S_CMP   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // Match counter increment that sticks at its maximum value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (c == CNT_MAX) begin
            r = c;
        end else begin
            r = c + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/jam_cost_acc.sv
// ---------------------------------------------------------------------------
// jam_cost_acc
// Cost-ROM address generator and accumulator for one permutation.
// On i_start_fetch the permutation is latched and N address cycles follow
// (W=k, J=job of worker k). ROM data returns one cycle after its address
// and is added to the running sum in that cycle.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   i_clear         zero the running sum
//   i_start_fetch   latch i_seq and begin the address sequence
//   i_seq           packed permutation, 4-bit nibble per worker (bit 3 unused)
//   i_min           current minimum (only with JAM_EARLY_ABORT_EN)
//   i_cost          ROM data, valid one cycle after o_w/o_j
//   o_w, o_j        ROM worker/job address, 0 while not fetching
//   o_fetch_done    high in the last address cycle
//   o_sum           accumulated cost
//   o_abort         running sum already exceeds i_min (JAM_EARLY_ABORT_EN)
// ---------------------------------------------------------------------------
module jam_cost_acc
    import jam_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 i_clear,
    input  logic                 i_start_fetch,
    input  logic [4*N-1:0]       i_seq,
`ifdef JAM_EARLY_ABORT_EN
    input  logic [SUM_W-1:0]     i_min,
`endif
    input  logic [COST_W-1:0]    i_cost,
    output logic [IDX_W-1:0]     o_w,
    output logic [IDX_W-1:0]     o_j,
    output logic                 o_fetch_done,
    output logic [SUM_W-1:0]     o_sum,
    output logic                 o_abort
);

    logic [N-1:0][IDX_W-1:0] r_jobs;
    logic [IDX_W-1:0]        r_k;
    logic [IDX_W-1:0]        r_w;
    logic [IDX_W-1:0]        r_j;
    logic                    r_active;
    logic                    r_cost_vld;
    logic [SUM_W-1:0]        r_sum;

    logic [N-1:0][IDX_W-1:0] w_jobs_in;
    logic [N-1:0]            w_unused_bits;
    logic [SUM_W-1:0]        w_sum_next;
    logic                    w_abort;
    logic                    w_fetch_done;

    // Split the packed permutation into 3-bit job indices; bit 3 is dropped.
    always_comb begin
        w_jobs_in     = {(N*IDX_W){1'b0}};
        w_unused_bits = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            w_jobs_in[i]     = i_seq[4*i +: IDX_W];
            w_unused_bits[i] = i_seq[4*i + 3];
        end
    end

    // Running sum including the cost arriving this cycle, and the abort test on it.
    always_comb begin
        w_sum_next   = r_sum + {{(SUM_W-COST_W){1'b0}}, i_cost};
        w_fetch_done = r_active && (r_k == K_LAST);
`ifdef JAM_EARLY_ABORT_EN
        w_abort      = r_cost_vld && (w_sum_next > i_min);
`else
        w_abort      = 1'b0;
`endif
    end

    // Address sequencer, read-valid pipeline and accumulator.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_jobs     <= {(N*IDX_W){1'b0}};
            r_k        <= {IDX_W{1'b0}};
            r_w        <= {IDX_W{1'b0}};
            r_j        <= {IDX_W{1'b0}};
            r_active   <= 1'b0;
            r_cost_vld <= 1'b0;
            r_sum      <= {SUM_W{1'b0}};
        end else begin
            // An abort drops the read still in flight.
            r_cost_vld <= r_active && !w_abort;

            if (i_clear) begin
                r_sum <= {SUM_W{1'b0}};
            end else if (r_cost_vld) begin
                r_sum <= w_sum_next;
            end else begin
                r_sum <= r_sum;
            end

            if (i_start_fetch) begin
                r_jobs   <= w_jobs_in;
                r_k      <= {IDX_W{1'b0}};
                r_w      <= {IDX_W{1'b0}};
                r_j      <= w_jobs_in[0];
                r_active <= 1'b1;
            end else if (r_active && !w_abort && !w_fetch_done) begin
                r_k      <= r_k + 3'd1;
                r_w      <= r_k + 3'd1;
                r_j      <= r_jobs[r_k + 3'd1];
                r_active <= 1'b1;
            end else begin
                r_k      <= {IDX_W{1'b0}};
                r_w      <= {IDX_W{1'b0}};
                r_j      <= {IDX_W{1'b0}};
                r_active <= 1'b0;
            end
        end
    end

    assign o_w          = r_w;
    assign o_j          = r_j;
    assign o_fetch_done = w_fetch_done;
    assign o_sum        = r_sum;
    assign o_abort      = w_abort;

endmodule

// File: rtl/jam_sched.sv
// ---------------------------------------------------------------------------
// jam_sched
// Job-assignment scheduler: for each permutation from the permutation engine
// it sums the N worker/job costs from the cost ROM and tracks the minimum
// total and how many permutations reach it.
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   start        begin a full search (only accepted in IDLE)
//   perm_req     one-cycle request for the next permutation
//   perm_ack     permutation valid on perm_seq/perm_last (only used in WAIT)
//   perm_seq     packed permutation, nibble i = job for worker i
//   perm_last    this is the final permutation
//   W, J, Cost   cost ROM address and data (data one cycle after address)
//   busy         high outside IDLE
//   MinCost      minimum total cost
//   MatchCount   number of permutations at MinCost (saturating)
//   Valid        one-cycle pulse, results final
// Optional feature: define JAM_EARLY_ABORT_EN to abandon a permutation as
// soon as its running sum exceeds the current minimum.
// ---------------------------------------------------------------------------
module jam_sched
    import jam_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    output logic                 perm_req,
    input  logic                 perm_ack,
    input  logic [4*N-1:0]       perm_seq,
    input  logic                 perm_last,
    output logic [IDX_W-1:0]     W,
    output logic [IDX_W-1:0]     J,
    input  logic [COST_W-1:0]    Cost,
    output logic                 busy,
    output logic [SUM_W-1:0]     MinCost,
    output logic [CNT_W-1:0]     MatchCount,
    output logic                 Valid
);

    state_t             r_state;
    state_t             w_next;
    logic               r_perm_req;
    logic               r_busy;
    logic               r_valid;
    logic               r_last;
    logic [SUM_W-1:0]   r_min;
    logic [SUM_W-1:0]   r_min_cost;
    logic [CNT_W-1:0]   r_count;

    logic               w_start_search;
    logic               w_start_fetch;
    logic               w_fetch_done;
    logic               w_abort;
    logic [SUM_W-1:0]   w_sum;

    assign w_start_search = (r_state == S_IDLE) && start;
    assign w_start_fetch  = (r_state == S_WAIT) && perm_ack;

    jam_cost_acc u_acc (
        .CLK           (CLK),
        .RST           (RST),
        .i_clear       (w_start_search | w_start_fetch),
        .i_start_fetch (w_start_fetch),
        .i_seq         (perm_seq),
`ifdef JAM_EARLY_ABORT_EN
        .i_min         (r_min),
`endif
        .i_cost        (Cost),
        .o_w           (W),
        .o_j           (J),
        .o_fetch_done  (w_fetch_done),
        .o_sum         (w_sum),
        .o_abort       (w_abort)
    );

    // Next-state logic; an aborted permutation skips straight to compare/done.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_REQ;
                else       w_next = S_IDLE;
            end
            S_REQ:  w_next = S_WAIT;
            S_WAIT: begin
                if (perm_ack) w_next = S_FETCH;
                else          w_next = S_WAIT;
            end
            S_FETCH: begin
                if (w_abort)           w_next = r_last ? S_DONE : S_CMP;
                else if (w_fetch_done) w_next = S_ACC;
                else                   w_next = S_FETCH;
            end
            S_ACC: begin
                if (w_abort) w_next = r_last ? S_DONE : S_CMP;
                else         w_next = S_CMP;
            end
            S_CMP: begin
                if (r_last) w_next = S_DONE;
                else        w_next = S_REQ;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register and the registered control outputs decoded from the next state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_perm_req <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_perm_req <= (w_next == S_REQ);
            r_busy     <= (w_next != S_IDLE);
            r_valid    <= (w_next == S_DONE);
        end
    end

    // Search results: cleared on start, updated by the compare step;
    // the last flag is captured together with the permutation.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_min      <= MIN_INIT;
            r_min_cost <= {SUM_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_last     <= 1'b0;
        end else begin
            if (w_start_search) begin
                r_min      <= MIN_INIT;
                r_min_cost <= MIN_INIT;
                r_count    <= {CNT_W{1'b0}};
            end else if (r_state == S_CMP) begin
                if (w_sum < r_min) begin
                    r_min      <= w_sum;
                    r_min_cost <= w_sum;
                    r_count    <= {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (w_sum == r_min) begin
                    r_count    <= sat_inc(r_count);
                end else begin
                    r_count    <= r_count;
                end
            end else begin
                r_count <= r_count;
            end

            if (w_start_fetch) begin
                r_last <= perm_last;
            end else begin
                r_last <= r_last;
            end
        end
    end

    assign perm_req   = r_perm_req;
    assign busy       = r_busy;
    assign Valid      = r_valid;
    assign MinCost    = r_min_cost;
    assign MatchCount = r_count;

endmodule
